// File: rtl/nn_pkg.sv
// Shared constants, loader state encoding and coordinate helpers for the
// image_loader / conv2d pipeline.
package nn_pkg;

    localparam int unsigned IMG_W   = 8;
    localparam int unsigned IMG_H   = 8;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned COORD_W = 5;
    localparam int unsigned NPIX    = IMG_W * IMG_H;
    localparam int unsigned ADDR_W  = $clog2(NPIX);
    localparam int unsigned CNT_W   = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } loader_state_t;

    // True when a signed coordinate lies in [0, lim); the sign bit is tested
    // before the value is widened, so negative coordinates never alias.
    function automatic logic pad_check(input logic signed [COORD_W-1:0] c,
                                       input int unsigned lim);
        logic [COORD_W-1:0] mag;
        mag = $unsigned(c);
        return (c[COORD_W-1] == 1'b0) && (32'(mag) < lim);
    endfunction

endpackage

// File: rtl/frame_buffer.sv
// NPIX x DATA_W pixel store: one synchronous write port and one registered
// zero-padded read port addressed by signed (x, y) coordinates.
module frame_buffer
    import nn_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      we,
    input  logic [ADDR_W-1:0]         waddr,
    input  logic [DATA_W-1:0]         wdata,
    input  logic signed [COORD_W-1:0] rd_x,
    input  logic signed [COORD_W-1:0] rd_y,
    output logic [DATA_W-1:0]         rd_data
);

    logic [DATA_W-1:0] mem [NPIX];
    logic              in_range_c;
    logic [ADDR_W-1:0] raddr_c;

    // Bounds check on the signed coordinates, then raster address from the
    // in-range unsigned values.
    always_comb begin
        in_range_c = pad_check(rd_x, IMG_W) && pad_check(rd_y, IMG_H);
        raddr_c    = ADDR_W'($unsigned(rd_y)) * ADDR_W'(IMG_W)
                   + ADDR_W'($unsigned(rd_x));
    end

    // Storage write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read with zero padding; sees the pre-write value on a
    // same-address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= in_range_c ? mem[raddr_c] : '0;
        end
    end

endmodule

// File: rtl/image_loader.sv
// Frame loader ahead of conv2d: collects one IMG_W x IMG_H frame pixel by
// pixel, holds it with loading_done high, and serves padded window reads.
module image_loader
    import nn_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      in_valid,
    input  logic                      in_sof,
    output logic                      in_ready,
    output logic                      loading_done,
    input  logic                      frame_release,
    input  logic signed [COORD_W-1:0] rd_x,
    input  logic signed [COORD_W-1:0] rd_y,
    output logic [DATA_W-1:0]         rd_data,
    output logic [CNT_W-1:0]          pix_count,
    output logic                      overrun
);

    loader_state_t     state;
    logic              accept_c;
    logic [ADDR_W-1:0] waddr_c;

    // A pixel is taken when ready; from IDLE only a start-of-frame pixel
    // counts, and any start-of-frame pixel lands at address 0.
    always_comb begin
        accept_c = in_valid && in_ready && ((state == LOAD) || in_sof);
        waddr_c  = in_sof ? '0 : ADDR_W'(pix_count);
    end

    // Loader FSM with registered handshake, status and counter outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            in_ready     <= 1'b0;
            loading_done <= 1'b0;
            pix_count    <= '0;
            overrun      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    overrun  <= 1'b0;
                    if (accept_c) begin
                        pix_count <= CNT_W'(1);
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    if (accept_c) begin
                        if (in_sof) begin
                            pix_count <= CNT_W'(1);
                        end else if (pix_count == CNT_W'(NPIX - 1)) begin
                            pix_count    <= CNT_W'(NPIX);
                            state        <= FULL;
                            in_ready     <= 1'b0;
                            loading_done <= 1'b1;
                        end else begin
                            pix_count <= pix_count + CNT_W'(1);
                        end
                    end
                end
                FULL: begin
                    if (in_valid) begin
                        overrun <= 1'b1;
                    end
                    if (frame_release) begin
                        state        <= IDLE;
                        in_ready     <= 1'b1;
                        loading_done <= 1'b0;
                        pix_count    <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    frame_buffer u_frame_buffer (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (accept_c),
        .waddr   (waddr_c),
        .wdata   (in_data),
        .rd_x    (rd_x),
        .rd_y    (rd_y),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_image_loader.sv
// Directed bench for image_loader: load, padding, overrun/release, restart,
// async reset and a gapped stream, all against hand-computed values.
module tb_image_loader;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_sof;
    logic              in_ready;
    logic              loading_done;
    logic              frame_release;
    logic signed [4:0] rd_x;
    logic signed [4:0] rd_y;
    logic [7:0]        rd_data;
    logic [6:0]        pix_count;
    logic              overrun;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] ref_pix [64];

    image_loader dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_sof        (in_sof),
        .in_ready      (in_ready),
        .loading_done  (loading_done),
        .frame_release (frame_release),
        .rd_x          (rd_x),
        .rd_y          (rd_y),
        .rd_data       (rd_data),
        .pix_count     (pix_count),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pix(input logic [7:0] d, input logic sof);
        in_data  = d;
        in_valid = 1'b1;
        in_sof   = sof;
        step();
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic read_px(input int x, input int y, input logic [7:0] exp, input string tag);
        rd_x = 5'(x);
        rd_y = 5'(y);
        step();
        chk(tag, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        rst_n = 1'b0;
        in_data = '0; in_valid = 1'b0; in_sof = 1'b0; frame_release = 1'b0;
        rd_x = '0; rd_y = '0;

        // Reset state
        step(); step();
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_done", 32'(loading_done), 0);
        chk("rst_pix_count", 32'(pix_count), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        rst_n = 1'b1;
        step();
        chk("idle_in_ready", 32'(in_ready), 1);

        // Full load, pixel value = addr + 1
        send_pix(8'd1, 1'b1);
        chk("load_first_count", 32'(pix_count), 1);
        for (int i = 1; i < 64; i++) begin
            if (i == 63) chk("load_done_before_last", 32'(loading_done), 0);
            send_pix(8'(i + 1), 1'b0);
        end
        chk("load_done", 32'(loading_done), 1);
        chk("load_count", 32'(pix_count), 64);
        chk("load_in_ready", 32'(in_ready), 0);
        read_px(3, 2, 8'd20, "rd_3_2");

        // Zero padding and corners
        read_px(-1, 0, 8'd0, "pad_m1_0");
        read_px(8, 3, 8'd0, "pad_8_3");
        read_px(0, -1, 8'd0, "pad_0_m1");
        read_px(7, 8, 8'd0, "pad_7_8");
        read_px(-8, 0, 8'd0, "pad_m8_0");
        read_px(0, -16, 8'd0, "pad_0_m16");
        read_px(15, 15, 8'd0, "pad_15_15");
        read_px(7, 7, 8'd64, "rd_7_7");
        read_px(0, 0, 8'd1, "rd_0_0");

        // Overrun then release
        send_pix(8'hAA, 1'b0);
        chk("ovr_set", 32'(overrun), 1);
        chk("ovr_count_hold", 32'(pix_count), 64);
        read_px(0, 0, 8'd1, "ovr_rd_0_0");
        chk("ovr_sticky", 32'(overrun), 1);
        frame_release = 1'b1;
        step();
        frame_release = 1'b0;
        chk("rel_done", 32'(loading_done), 0);
        chk("rel_count", 32'(pix_count), 0);
        chk("rel_in_ready", 32'(in_ready), 1);
        step();
        chk("rel_overrun", 32'(overrun), 0);
        chk("idle_release_ignored", 32'(loading_done), 0);

        // Restart mid-frame
        send_pix(8'd9, 1'b1);
        for (int i = 1; i < 10; i++) send_pix(8'(9 + i), 1'b0);
        chk("rs_count10", 32'(pix_count), 10);
        send_pix(8'h55, 1'b1);
        chk("rs_count1", 32'(pix_count), 1);
        for (int i = 1; i < 64; i++) send_pix(8'(i) ^ 8'h3C, 1'b0);
        chk("rs_done", 32'(loading_done), 1);
        read_px(0, 0, 8'h55, "rs_rd_0_0");
        read_px(1, 0, 8'h3D, "rs_rd_1_0");
        read_px(7, 7, 8'h03, "rs_rd_7_7");

        // Release and start-of-frame in the same FULL cycle: release wins
        in_data = 8'h77; in_valid = 1'b1; in_sof = 1'b1; frame_release = 1'b1;
        step();
        in_valid = 1'b0; in_sof = 1'b0; frame_release = 1'b0;
        chk("race_done", 32'(loading_done), 0);
        chk("race_overrun_set", 32'(overrun), 1);
        chk("race_count", 32'(pix_count), 0);
        step();
        chk("race_overrun_clr", 32'(overrun), 0);
        chk("race_count_idle", 32'(pix_count), 0);
        read_px(0, 0, 8'h55, "race_rd_0_0");

        // Async reset mid-LOAD
        send_pix(8'd1, 1'b1);
        for (int i = 1; i < 30; i++) send_pix(8'(i), 1'b0);
        frame_release = 1'b1;
        step();
        frame_release = 1'b0;
        chk("load_release_ignored", 32'(pix_count), 30);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", 32'(in_ready), 0);
        chk("arst_count", 32'(pix_count), 0);
        chk("arst_rd_data", 32'(rd_data), 0);
        step();
        rst_n = 1'b1;
        step();
        chk("arst_idle_ready", 32'(in_ready), 1);
        send_pix(8'h12, 1'b0);
        chk("arst_nosof_count", 32'(pix_count), 0);
        send_pix(8'h13, 1'b0);
        chk("arst_nosof_done", 32'(loading_done), 0);

        // Gapped stream with random values
        for (int i = 0; i < 64; i++) ref_pix[i] = 8'($urandom);
        for (int i = 0; i < 64; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                step();
                chk($sformatf("gap_done_%0d", i), 32'(loading_done), 0);
            end
            send_pix(ref_pix[i], (i == 0) ? 1'b1 : 1'b0);
            if (i < 63) chk($sformatf("gap_count_%0d", i), 32'(pix_count), 32'(i + 1));
        end
        chk("gap_done", 32'(loading_done), 1);
        for (int a = 0; a < 64; a++)
            read_px(a % 8, a / 8, ref_pix[a], $sformatf("gap_rd_%0d", a));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/image_loader.md
Name: image_loader

Overview:
- Upstream stage of the conv2d stage in the tt_um_mark28277 pipeline.
- Accepts an IMG_W x IMG_H image one pixel per handshake over the 8-bit dedicated input bus and stores it in an internal frame buffer.
- Raises loading_done, which is the conv2d start_processing strobe.
- Serves zero-padded random-access pixel reads for the 3x3 convolution window until the consumer releases the frame.

Parameters:
- IMG_W, 8, image width in pixels
- IMG_H, 8, image height in pixels
- DATA_W, 8, pixel width in bits
- COORD_W, 5, width of signed read coordinates (range -16..15)

Ports:
- clk  in  1  clock; all state changes on its rising edge
- rst_n  in  1  reset; asynchronous assert, active-low
- in_data  in  DATA_W  pixel byte (top level drives it from ui_in)
- in_valid  in  1  pixel strobe (top level drives it from uio_in[0])
- in_sof  in  1  start-of-frame qualifier; sampled only while in_valid=1 (top level drives it from uio_in[1])
- in_ready  out  1  loader accepts a pixel this cycle
- loading_done  out  1  frame complete and held; level signal
- frame_release  in  1  consumer finished; frees the buffer
- rd_x  in  COORD_W  signed read column
- rd_y  in  COORD_W  signed read row
- rd_data  out  DATA_W  registered pixel at (rd_x, rd_y), zero when out of range
- pix_count  out  7  pixels accepted in the current frame
- overrun  out  1  sticky: in_valid seen while in_ready=0

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State to IDLE.
  - in_ready=0, loading_done=0, rd_data=0, pix_count=0, overrun=0.
  - Buffer contents are don't-care; the buffer is not reset.
- FSM states:
  - IDLE: in_ready=1. in_valid&in_sof writes pixel 0, sets pix_count=1 and goes to LOAD. in_valid without in_sof is discarded, with no overrun.
  - LOAD: in_ready=1. Each in_valid writes buffer[pix_count] in raster order (addr = y*IMG_W + x) and increments pix_count.
    - in_valid&in_sof restarts the frame: the pixel goes to address 0 and pix_count=1.
    - When the accepted pixel brings pix_count to IMG_W*IMG_H, go to FULL.
  - FULL: in_ready=0, loading_done=1, pix_count holds 64.
    - in_valid sets overrun; the data is dropped.
    - frame_release moves to IDLE, clears loading_done and pix_count, and clears overrun next cycle.
- Timing of done: loading_done rises on the clock edge after the 64th accepted pixel, i.e. 1 cycle after the handshake.
- frame_release outside FULL is ignored.
- If frame_release and in_valid&in_sof occur in the same cycle in FULL, the release wins and the pixel is dropped; overrun is set, then cleared by the IDLE entry.
- Read port:
  - 1-cycle latency: rd_data at edge N+1 reflects rd_x/rd_y at edge N.
  - rd_data=0 if rd_x<0, rd_x>=IMG_W, rd_y<0 or rd_y>=IMG_H (zero padding).
  - Reads are valid in any state; they return buffer contents as-is.
  - A read and a write to the same address in one cycle returns the old value (read-before-write).
- Arithmetic:
  - Address is computed on the unsigned in-range coordinate after the bounds check.
  - The sign bit is checked before any truncation.
  - No wrap-around: coordinate -1 never aliases to 7.
- Reset mid-LOAD abandons the frame. A new frame requires in_sof.

Decomposition:
- Shared package nn_pkg holds:
  - IMG_W, IMG_H, DATA_W, COORD_W and NPIX = IMG_W*IMG_H.
  - The loader state enum {IDLE, LOAD, FULL}.
  - A pad_check function (coordinate in range) reused by conv2d.
- One natural sub-module: frame_buffer.
  - NPIX x DATA_W storage.
  - One synchronous write port and one synchronous read port with zero-pad gating.
  - Keeps the loader FSM separate from storage so a later SRAM macro swap is localised.

Test Plan:
- Full load: reset, then in_sof with pixel 0, then 64 pixels valued addr+1 on consecutive cycles.
  - Expect loading_done=1 exactly 1 cycle after the 64th handshake and pix_count=64.
  - Then read (3,2): rd_data=20 one cycle later.
- Padding: in FULL, read (-1,0), (8,3), (0,-1) and (7,8) -> rd_data=0 each.
  - Read (7,7) -> 64. Read (0,0) -> 1.
- Overrun and release: in FULL, pulse in_valid with data 0xAA.
  - Expect overrun=1 and (0,0) still 1.
  - Pulse frame_release: loading_done=0 next cycle, overrun=0, pix_count=0, in_ready=1.
- Restart mid-frame: load 10 pixels, then in_sof with 0x55.
  - Expect pix_count=1.
  - After 63 more pixels, loading_done=1 and (0,0)=0x55.
- Async reset mid-LOAD: drop rst_n between clock edges after 30 pixels.
  - Expect in_ready=0 and pix_count=0 immediately, before the next edge.
  - After release, in_valid without in_sof leaves pix_count=0.
- Gapped stream: 64 pixels with random in_valid gaps of 0-3 cycles.
  - Expect all addresses to read back correct values and loading_done to rise only after the last pixel.
